// File: rtl/ptr_pkg.sv
// Shared definitions for the photo tape reader path: controller states,
// the block stop code, and the word-time timer width.
package ptr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        READ,
        GAP,
        REV_ACCEL,
        REVERSE,
        DECEL
    } ptr_state_t;

    localparam logic [4:0] STOP_CODE = 5'b10000;
    localparam int         TMR_W     = 4;

    function automatic logic is_rev_state(input ptr_state_t s);
        return (s == REV_ACCEL) || (s == REVERSE);
    endfunction

endpackage

// File: rtl/ptr_ctl_wt_timer.sv
// Loadable word-time down-counter. done fires on the T0 that takes the count
// to zero, so a load of N ends the phase on the N-th following T0.
module wt_timer
    import ptr_pkg::*;
#(
    parameter int W = TMR_W
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (tick && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = tick && (cnt_reg <= W'(1));

endmodule

// File: rtl/ptr_ctl.sv
// Photo tape reader controller: motor start ramp, per-character stepping,
// stop-code block end, stop ramp and block reverse for re-read.
module ptr_ctl
    import ptr_pkg::*;
#(
    parameter int ACCEL_WT = 4,
    parameter int CHAR_WT  = 2,
    parameter int DECEL_WT = 3,
    parameter int BLK_W    = 12
)(
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       T0,
    input  logic       TAPE_FWD,
    input  logic       TAPE_REV_REQ,
    input  logic [4:0] TS_CHAR,
    input  logic       TS_VALID,
    input  logic       TS_EOT,
    output logic       TS_STEP,
    output logic       TS_DIR,
    output logic       CHAR_STB,
    output logic [4:0] CHAR_CODE,
    output logic       STOP_SEEN,
    output logic       PL6_PHOTO_TAPE_REV,
    output logic       READER_BUSY,
    output logic       TAPE_FAULT
);

    localparam logic [BLK_W-1:0] BLK_MAX = '1;
    // The sample/step T0 itself counts as the last word time of ACCEL and GAP.
    localparam logic [TMR_W-1:0] ACCEL_VAL = TMR_W'(ACCEL_WT - 1);
    localparam logic [TMR_W-1:0] GAP_VAL   = TMR_W'(CHAR_WT - 1);
    localparam logic [TMR_W-1:0] STEP_VAL  = TMR_W'(CHAR_WT);
    localparam logic [TMR_W-1:0] DECEL_VAL = TMR_W'(DECEL_WT);
    localparam logic [TMR_W-1:0] FIRST_VAL = TMR_W'(1);

    ptr_state_t       state_reg, state_next;
    logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic [BLK_W-1:0] last_blk_reg, last_blk_next;
    logic [BLK_W-1:0] rcnt_reg, rcnt_next;
    logic [4:0]       char_code_reg, char_code_next;
    logic             fault_reg, fault_next;
    logic             dir_reg, dir_next;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             read_hit, rev_step;

    function automatic logic [BLK_W-1:0] sat_inc(input logic [BLK_W-1:0] v);
        return (v == BLK_MAX) ? v : v + 1'b1;
    endfunction

    wt_timer #(.W(TMR_W)) u_timer (
        .clk      (CLOCK),
        .rst      (rst),
        .tick     (T0),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign read_hit = (state_reg == READ) && T0 && !TS_EOT && TS_VALID;
    assign rev_step = (state_reg == REVERSE) && (rcnt_reg != '0) && !TS_EOT && tmr_done;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            blk_cnt_reg   <= '0;
            last_blk_reg  <= '0;
            rcnt_reg      <= '0;
            char_code_reg <= '0;
            fault_reg     <= 1'b0;
            dir_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            blk_cnt_reg   <= blk_cnt_next;
            last_blk_reg  <= last_blk_next;
            rcnt_reg      <= rcnt_next;
            char_code_reg <= char_code_next;
            fault_reg     <= fault_next;
            dir_reg       <= dir_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        blk_cnt_next   = blk_cnt_reg;
        last_blk_next  = last_blk_reg;
        rcnt_next      = rcnt_reg;
        char_code_next = char_code_reg;
        fault_next     = fault_reg;
        dir_next       = dir_reg;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        case (state_reg)
            IDLE: begin
                // Forward wins a simultaneous request; reverse needs a block to undo.
                if (TAPE_FWD) begin
                    state_next = ACCEL;
                    dir_next   = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_val    = ACCEL_VAL;
                end else if (TAPE_REV_REQ && (last_blk_reg != '0)) begin
                    state_next = REV_ACCEL;
                    dir_next   = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = ACCEL_VAL;
                end
            end
            ACCEL, GAP: begin
                if (!TAPE_FWD) begin
                    state_next = DECEL;
                    tmr_load   = 1'b1;
                    tmr_val    = DECEL_VAL;
                end else if (tmr_done) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (T0 && TS_EOT) begin
                    fault_next = 1'b1;
                    state_next = DECEL;
                    tmr_load   = 1'b1;
                    tmr_val    = DECEL_VAL;
                end else if (read_hit) begin
                    char_code_next = TS_CHAR;
                    tmr_load       = 1'b1;
                    if (TS_CHAR == STOP_CODE) begin
                        last_blk_next = sat_inc(blk_cnt_reg);
                        blk_cnt_next  = '0;
                        state_next    = DECEL;
                        tmr_val       = DECEL_VAL;
                    end else begin
                        blk_cnt_next = sat_inc(blk_cnt_reg);
                        state_next   = GAP;
                        tmr_val      = GAP_VAL;
                    end
                end
            end
            REV_ACCEL: begin
                if (tmr_done) begin
                    state_next = REVERSE;
                    rcnt_next  = last_blk_reg;
                    tmr_load   = 1'b1;
                    tmr_val    = FIRST_VAL;
                end
            end
            REVERSE: begin
                if (rcnt_reg == '0) begin
                    blk_cnt_next = '0;
                    state_next   = DECEL;
                    tmr_load     = 1'b1;
                    tmr_val      = DECEL_VAL;
                end else if (T0 && TS_EOT) begin
                    fault_next = 1'b1;
                    state_next = DECEL;
                    tmr_load   = 1'b1;
                    tmr_val    = DECEL_VAL;
                end else if (rev_step) begin
                    rcnt_next = rcnt_reg - 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = STEP_VAL;
                end
            end
            DECEL: begin
                if (tmr_done) begin
                    state_next = IDLE;
                    dir_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        TS_STEP            = read_hit || rev_step;
        TS_DIR             = dir_reg;
        CHAR_STB           = read_hit;
        CHAR_CODE          = char_code_reg;
        STOP_SEEN          = read_hit && (TS_CHAR == STOP_CODE);
        PL6_PHOTO_TAPE_REV = is_rev_state(state_reg);
        READER_BUSY        = (state_reg != IDLE);
        TAPE_FAULT         = fault_reg;
    end

endmodule

// File: tb/tb_ptr_ctl.sv
// Scoreboard bench for ptr_ctl: a tape model feeds the head, stimulus queues
// the expected strobes/steps, and a negedge monitor pops and compares them.
module tb_ptr_ctl;
    import ptr_pkg::*;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       T0 = 1'b0;
    logic       TAPE_FWD = 1'b0;
    logic       TAPE_REV_REQ = 1'b0;
    logic [4:0] TS_CHAR;
    logic       TS_VALID = 1'b1;
    logic       TS_EOT = 1'b0;
    logic       TS_STEP, TS_DIR, CHAR_STB, STOP_SEEN;
    logic       PL6_PHOTO_TAPE_REV, READER_BUSY, TAPE_FAULT;
    logic [4:0] CHAR_CODE;

    ptr_ctl dut (
        .CLOCK              (CLOCK),
        .rst                (rst),
        .T0                 (T0),
        .TAPE_FWD           (TAPE_FWD),
        .TAPE_REV_REQ       (TAPE_REV_REQ),
        .TS_CHAR            (TS_CHAR),
        .TS_VALID           (TS_VALID),
        .TS_EOT             (TS_EOT),
        .TS_STEP            (TS_STEP),
        .TS_DIR             (TS_DIR),
        .CHAR_STB           (CHAR_STB),
        .CHAR_CODE          (CHAR_CODE),
        .STOP_SEEN          (STOP_SEEN),
        .PL6_PHOTO_TAPE_REV (PL6_PHOTO_TAPE_REV),
        .READER_BUSY        (READER_BUSY),
        .TAPE_FAULT         (TAPE_FAULT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       is_step;
        logic [4:0] code;
        logic       stop;
        int         t0;
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         t0_num = 0;
    int         phase = 0;
    int         base_t0 = 0;
    int         pos = 8;
    logic       rev_ok = 1'b0;
    logic       code_pend = 1'b0;
    logic [4:0] code_exp = '0;
    logic       tm_step, tm_dir;
    logic [4:0] tape [0:63];

    wire [11:0] outs = {TS_STEP, TS_DIR, CHAR_STB, CHAR_CODE, STOP_SEEN,
                        PL6_PHOTO_TAPE_REV, READER_BUSY, TAPE_FAULT};

    assign TS_CHAR = tape[pos[5:0]];

    // One T0 every four clocks.
    initial forever begin
        @(posedge CLOCK);
        #1;
        phase = (phase + 1) % 4;
        T0 = (phase == 0);
        if (phase == 0) t0_num++;
    end

    // Tape head moves after each clock edge that consumed a step pulse.
    initial forever begin
        @(negedge CLOCK);
        tm_step = TS_STEP;
        tm_dir  = TS_DIR;
        @(posedge CLOCK);
        #3;
        if (tm_step === 1'b1) pos = (tm_dir === 1'b1) ? pos - 1 : pos + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got event at t0 +%0d expected none", name, t0_num - base_t0);
    endtask

    always @(negedge CLOCK) begin
        ev_t e;
        if (code_pend) begin
            code_pend = 1'b0;
            chk("char_code", CHAR_CODE, code_exp);
        end
        if (CHAR_STB === 1'b1 || (TS_STEP === 1'b1 && TS_DIR === 1'b1)) begin
            if (exp_q.size() == 0) begin
                flag_fail(CHAR_STB ? "unexpected_char_stb" : "unexpected_rev_step");
            end else begin
                e = exp_q.pop_front();
                chk("event_is_step", (CHAR_STB === 1'b1) ? 0 : 1, e.is_step);
                chk(e.is_step ? "rev_step_t0" : "char_stb_t0", t0_num - base_t0, e.t0);
                if (e.is_step) begin
                    chk("rev_level_at_step", PL6_PHOTO_TAPE_REV, 1);
                end else begin
                    chk("stop_seen", STOP_SEEN, e.stop);
                    code_pend = 1'b1;
                    code_exp  = e.code;
                end
            end
        end
        if (CHAR_STB === 1'b1 && !(TS_STEP === 1'b1 && TS_DIR === 1'b0))
            flag_fail("stb_without_fwd_step");
        if (TS_STEP === 1'b1 && TS_DIR === 1'b0 && CHAR_STB !== 1'b1)
            flag_fail("fwd_step_without_stb");
        if (STOP_SEEN === 1'b1 && CHAR_STB !== 1'b1)
            flag_fail("stop_seen_without_stb");
        if (PL6_PHOTO_TAPE_REV === 1'b1 && !rev_ok)
            flag_fail("rev_level_unexpected");
    end

    task automatic push(input logic is_step, input logic [4:0] code, input logic stop, input int t0);
        ev_t e;
        e.is_step = is_step;
        e.code    = code;
        e.stop    = stop;
        e.t0      = t0;
        exp_q.push_back(e);
    endtask

    task automatic sync_t0();
        @(negedge CLOCK);
        while (T0 !== 1'b1) @(negedge CLOCK);
        @(posedge CLOCK);
        #2;
        base_t0 = t0_num;
    endtask

    task automatic wait_t0(input int n);
        @(negedge CLOCK);
        while (!(T0 === 1'b1 && t0_num == base_t0 + n)) @(negedge CLOCK);
        @(posedge CLOCK);
        #2;
    endtask

    task automatic put(input int off, input logic [4:0] c);
        tape[pos + off] = c;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) tape[i] = '0;

        repeat (3) @(negedge CLOCK);
        chk("reset_outputs", outs, 0);
        @(posedge CLOCK);
        #2 rst = 1'b0;
        @(negedge CLOCK);
        chk("post_reset_outputs", outs, 0);

        // Block "3,5,STOP"
        put(0, 5'd3); put(1, 5'd5); put(2, STOP_CODE);
        sync_t0();
        TAPE_FWD = 1'b1;
        push(0, 5'd3, 0, 4); push(0, 5'd5, 0, 6); push(0, STOP_CODE, 1, 8);
        wait_t0(8);
        TAPE_FWD = 1'b0;
        chk("busy_in_decel", READER_BUSY, 1);
        wait_t0(10);
        chk("busy_decel_last", READER_BUSY, 1);
        wait_t0(11);
        chk("busy_after_decel", READER_BUSY, 0);

        // Reverse the 3-character block
        sync_t0();
        rev_ok = 1'b1;
        TAPE_REV_REQ = 1'b1;
        push(1, 5'd0, 0, 4); push(1, 5'd0, 0, 6); push(1, 5'd0, 0, 8);
        @(posedge CLOCK);
        #2 TAPE_REV_REQ = 1'b0;
        chk("rev_level_accel", PL6_PHOTO_TAPE_REV, 1);
        chk("dir_reverse", TS_DIR, 1);
        wait_t0(11);
        chk("busy_after_reverse", READER_BUSY, 0);
        chk("rev_level_idle", PL6_PHOTO_TAPE_REV, 0);
        rev_ok = 1'b0;

        // FWD and REV_REQ together: forward re-read of the same block
        sync_t0();
        TAPE_FWD = 1'b1;
        TAPE_REV_REQ = 1'b1;
        push(0, 5'd3, 0, 4); push(0, 5'd5, 0, 6); push(0, STOP_CODE, 1, 8);
        @(posedge CLOCK);
        #2 TAPE_REV_REQ = 1'b0;
        chk("dir_forward", TS_DIR, 0);
        wait_t0(8);
        TAPE_FWD = 1'b0;
        wait_t0(11);
        chk("busy_after_reread", READER_BUSY, 0);

        // FWD dropped in GAP after two characters
        put(0, 5'd7); put(1, 5'd9); put(2, 5'd11); put(3, STOP_CODE);
        sync_t0();
        TAPE_FWD = 1'b1;
        push(0, 5'd7, 0, 4); push(0, 5'd9, 0, 6);
        wait_t0(6);
        TAPE_FWD = 1'b0;
        wait_t0(9);
        chk("busy_after_gap_drop", READER_BUSY, 0);

        // Partial count of 2 carries: "1,STOP" closes a block of 4
        put(0, 5'd1); put(1, STOP_CODE);
        sync_t0();
        TAPE_FWD = 1'b1;
        push(0, 5'd1, 0, 4); push(0, STOP_CODE, 1, 6);
        wait_t0(6);
        TAPE_FWD = 1'b0;
        wait_t0(9);
        chk("busy_after_short_block", READER_BUSY, 0);

        sync_t0();
        rev_ok = 1'b1;
        TAPE_REV_REQ = 1'b1;
        push(1, 5'd0, 0, 4); push(1, 5'd0, 0, 6); push(1, 5'd0, 0, 8); push(1, 5'd0, 0, 10);
        @(posedge CLOCK);
        #2 TAPE_REV_REQ = 1'b0;
        wait_t0(13);
        chk("busy_after_reverse4", READER_BUSY, 0);
        rev_ok = 1'b0;

        // EOT at the first READ sample
        put(0, 5'd2); put(1, 5'd6); put(2, STOP_CODE);
        sync_t0();
        TAPE_FWD = 1'b1;
        TS_EOT = 1'b1;
        chk("fault_before_eot", TAPE_FAULT, 0);
        wait_t0(4);
        TAPE_FWD = 1'b0;
        TS_EOT = 1'b0;
        chk("fault_set_on_eot", TAPE_FAULT, 1);
        wait_t0(7);
        chk("busy_after_eot", READER_BUSY, 0);
        chk("fault_sticky_idle", TAPE_FAULT, 1);

        sync_t0();
        TAPE_FWD = 1'b1;
        push(0, 5'd2, 0, 4); push(0, 5'd6, 0, 6); push(0, STOP_CODE, 1, 8);
        wait_t0(8);
        TAPE_FWD = 1'b0;
        chk("fault_sticky_read", TAPE_FAULT, 1);
        wait_t0(11);
        chk("busy_after_fault_read", READER_BUSY, 0);

        // Reset in the middle of a reverse
        sync_t0();
        rev_ok = 1'b1;
        TAPE_REV_REQ = 1'b1;
        push(1, 5'd0, 0, 4);
        @(posedge CLOCK);
        #2 TAPE_REV_REQ = 1'b0;
        wait_t0(4);
        rst = 1'b1;
        @(negedge CLOCK);
        chk("outputs_after_mid_rst", outs, 0);
        rev_ok = 1'b0;
        repeat (2) @(posedge CLOCK);
        #2 rst = 1'b0;

        sync_t0();
        TAPE_REV_REQ = 1'b1;
        @(posedge CLOCK);
        #2 TAPE_REV_REQ = 1'b0;
        chk("busy_rev_noop", READER_BUSY, 0);
        wait_t0(6);
        chk("outputs_rev_noop", outs, 0);

        @(negedge CLOCK);
        chk("scoreboard_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
